// File: rtl/pcap_replay_pacer.sv
// Trace replay pacer: holds each captured packet descriptor until the time elapsed
// since the first packet reaches that packet's capture offset, then releases it.
module pcap_replay_pacer #(
  parameter int TS_WIDTH   = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int NS_PER_CLK = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CTRL_START,
  input  logic                 CTRL_STOP,
  input  logic [TS_WIDTH-1:0]  IN_TS,
  input  logic [LEN_WIDTH-1:0] IN_LEN,
  input  logic                 IN_LAST,
  input  logic                 IN_VLD,
  output logic                 IN_DST_RDY,
  output logic [LEN_WIDTH-1:0] OUT_LEN,
  output logic                 OUT_VLD,
  input  logic                 OUT_DST_RDY,
  output logic                 STS_BUSY,
  output logic [CNT_WIDTH-1:0] STS_PKT_CNT,
  output logic [CNT_WIDTH-1:0] STS_LATE_CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  localparam logic [TS_WIDTH:0] STEP = (TS_WIDTH+1)'(NS_PER_CLK);

  state_t                 state_r, next_state_s;
  logic [TS_WIDTH-1:0]    elapsed_r, base_r, target_r, target_s;
  logic [TS_WIDTH:0]      elapsed_sum_s;
  logic [LEN_WIDTH-1:0]   len_r;
  logic                   last_r, stop_pending_r;
  logic [CNT_WIDTH-1:0]   pkt_cnt_r, late_cnt_r;
  logic                   in_xfer_s, out_xfer_s, accept_s;

  assign in_xfer_s     = IN_VLD & IN_DST_RDY;
  assign out_xfer_s    = OUT_VLD & OUT_DST_RDY;
  // a stop in the accept cycle still consumes the descriptor but throws it away
  assign accept_s      = in_xfer_s & ~CTRL_STOP;
  assign elapsed_sum_s = {1'b0, elapsed_r} + STEP;

  // Relative capture offset of the incoming descriptor, clamped at zero
  always_comb begin
    target_s = '0;
    if (IN_TS < base_r) begin
      target_s = '0;
    end else begin
      target_s = IN_TS - base_r;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (CTRL_START && !CTRL_STOP) next_state_s = S_FIRST;
        else                          next_state_s = S_IDLE;
      end
      S_FIRST: begin
        if (CTRL_STOP)      next_state_s = S_IDLE;
        else if (in_xfer_s) next_state_s = S_SEND;
        else                next_state_s = S_FIRST;
      end
      S_FETCH: begin
        if (CTRL_STOP)                 next_state_s = S_IDLE;
        else if (!in_xfer_s)           next_state_s = S_FETCH;
        else if (elapsed_r >= target_s) next_state_s = S_SEND;
        else                           next_state_s = S_WAIT;
      end
      S_WAIT: begin
        if (CTRL_STOP)                  next_state_s = S_IDLE;
        else if (elapsed_r >= target_r) next_state_s = S_SEND;
        else                            next_state_s = S_WAIT;
      end
      S_SEND: begin
        if (!out_xfer_s)                                  next_state_s = S_SEND;
        else if (last_r || stop_pending_r || CTRL_STOP)   next_state_s = S_IDLE;
        else                                              next_state_s = S_FETCH;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    IN_DST_RDY = 1'b0;
    OUT_VLD    = 1'b0;
    STS_BUSY   = 1'b1;
    case (state_r)
      S_IDLE:  STS_BUSY   = 1'b0;
      S_FIRST: IN_DST_RDY = 1'b1;
      S_FETCH: IN_DST_RDY = 1'b1;
      S_WAIT:  STS_BUSY   = 1'b1;
      S_SEND:  OUT_VLD    = 1'b1;
      default: STS_BUSY   = 1'b0;
    endcase
  end

  // Datapath: timebase, held descriptor, stop flag and statistics
  always_ff @(posedge CLK) begin
    if (RESET) begin
      elapsed_r      <= '0;
      base_r         <= '0;
      target_r       <= '0;
      len_r          <= '0;
      last_r         <= 1'b0;
      stop_pending_r <= 1'b0;
      pkt_cnt_r      <= '0;
      late_cnt_r     <= '0;
    end else begin
      if (state_r == S_FIRST && in_xfer_s) begin
        elapsed_r <= '0;
      end else if (state_r != S_IDLE) begin
        elapsed_r <= elapsed_sum_s[TS_WIDTH] ? '1 : elapsed_sum_s[TS_WIDTH-1:0];
      end

      if (state_r == S_FIRST && accept_s) begin
        base_r   <= IN_TS;
        target_r <= '0;
        len_r    <= IN_LEN;
        last_r   <= IN_LAST;
      end else if (state_r == S_FETCH && accept_s) begin
        target_r <= target_s;
        len_r    <= IN_LEN;
        last_r   <= IN_LAST;
        if (elapsed_r > target_s) late_cnt_r <= late_cnt_r + CNT_WIDTH'(1);
      end

      if (out_xfer_s) pkt_cnt_r <= pkt_cnt_r + CNT_WIDTH'(1);

      if (next_state_s == S_IDLE) begin
        stop_pending_r <= 1'b0;
      end else if (state_r == S_SEND && CTRL_STOP) begin
        stop_pending_r <= 1'b1;
      end
    end
  end

  assign OUT_LEN      = len_r;
  assign STS_PKT_CNT  = pkt_cnt_r;
  assign STS_LATE_CNT = late_cnt_r;

endmodule

// File: tb/tb_pcap_replay_pacer.sv
// Directed bench for pcap_replay_pacer: pacing, late release, clamp, stop and reset cases.
module tb_pcap_replay_pacer;

  logic        CLK, RESET, CTRL_START, CTRL_STOP;
  logic [63:0] IN_TS;
  logic [15:0] IN_LEN;
  logic        IN_LAST, IN_VLD, IN_DST_RDY;
  logic [15:0] OUT_LEN;
  logic        OUT_VLD, OUT_DST_RDY, STS_BUSY;
  logic [31:0] STS_PKT_CNT, STS_LATE_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base;
  int held;
  int seen;

  pcap_replay_pacer dut (
    .CLK(CLK), .RESET(RESET), .CTRL_START(CTRL_START), .CTRL_STOP(CTRL_STOP),
    .IN_TS(IN_TS), .IN_LEN(IN_LEN), .IN_LAST(IN_LAST), .IN_VLD(IN_VLD),
    .IN_DST_RDY(IN_DST_RDY), .OUT_LEN(OUT_LEN), .OUT_VLD(OUT_VLD),
    .OUT_DST_RDY(OUT_DST_RDY), .STS_BUSY(STS_BUSY), .STS_PKT_CNT(STS_PKT_CNT),
    .STS_LATE_CNT(STS_LATE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b1; CTRL_START = 1'b0; CTRL_STOP = 1'b0;
    IN_TS = 64'd0; IN_LEN = 16'd0; IN_LAST = 1'b0; IN_VLD = 1'b0; OUT_DST_RDY = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic start();
    CTRL_START = 1'b1;
    step();
    CTRL_START = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (!OUT_VLD && n < budget) begin
      step();
      n++;
    end
  endtask

  // Two-packet prologue: pkt1 ts=1000 len=64 released, pkt2 ts=1100 len=128 accepted into WAIT
  task automatic two_pkt_prologue();
    start();
    IN_VLD = 1'b1; IN_TS = 64'd1000; IN_LEN = 16'd64; IN_LAST = 1'b0;
    step();
    base = cyc;
    IN_TS = 64'd1100; IN_LEN = 16'd128;
    step();
    step();
    IN_VLD = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_in_rdy",  64'(IN_DST_RDY), 64'd0);
    check_eq("rst_out_vld", 64'(OUT_VLD), 64'd0);
    check_eq("rst_out_len", 64'(OUT_LEN), 64'd0);
    check_eq("rst_busy",    64'(STS_BUSY), 64'd0);
    check_eq("rst_pkt",     64'(STS_PKT_CNT), 64'd0);
    check_eq("rst_late",    64'(STS_LATE_CNT), 64'd0);

    // Nominal trace 1000/1100/1500, last on third
    start();
    check_eq("s1_rdy_after_start", 64'(IN_DST_RDY), 64'd1);
    check_eq("s1_busy", 64'(STS_BUSY), 64'd1);
    IN_VLD = 1'b1; IN_TS = 64'd1000; IN_LEN = 16'd64; IN_LAST = 1'b0;
    step();
    base = cyc;
    check_eq("s1_p1_vld", 64'(OUT_VLD), 64'd1);
    check_eq("s1_p1_len", 64'(OUT_LEN), 64'd64);
    IN_TS = 64'd1100; IN_LEN = 16'd128;
    step();
    step();
    IN_TS = 64'd1500; IN_LEN = 16'd256; IN_LAST = 1'b1;
    check_eq("s1_wait_vld", 64'(OUT_VLD), 64'd0);
    wait_out(60);
    check_eq("s1_p2_cycle", 64'(cyc - base), 64'd21);
    check_eq("s1_p2_len", 64'(OUT_LEN), 64'd128);
    step();
    step();
    IN_VLD = 1'b0; IN_LAST = 1'b0;
    wait_out(120);
    check_eq("s1_p3_cycle", 64'(cyc - base), 64'd101);
    check_eq("s1_p3_len", 64'(OUT_LEN), 64'd256);
    step();
    check_eq("s1_end_busy", 64'(STS_BUSY), 64'd0);
    check_eq("s1_end_vld",  64'(OUT_VLD), 64'd0);
    check_eq("s1_end_pkt",  64'(STS_PKT_CNT), 64'd3);
    check_eq("s1_end_late", 64'(STS_LATE_CNT), 64'd0);

    // Back-pressure on pkt1 for 50 cycles makes pkt2 late
    do_reset();
    start();
    IN_VLD = 1'b1; IN_TS = 64'd1000; IN_LEN = 16'd64; IN_LAST = 1'b0;
    step();
    IN_TS = 64'd1100; IN_LEN = 16'd128;
    OUT_DST_RDY = 1'b0;
    repeat (50) step();
    check_eq("s2_p1_held_vld", 64'(OUT_VLD), 64'd1);
    check_eq("s2_p1_held_len", 64'(OUT_LEN), 64'd64);
    OUT_DST_RDY = 1'b1;
    step();
    step();
    IN_VLD = 1'b0;
    check_eq("s2_p2_vld",  64'(OUT_VLD), 64'd1);
    check_eq("s2_p2_len",  64'(OUT_LEN), 64'd128);
    check_eq("s2_late",    64'(STS_LATE_CNT), 64'd1);
    check_eq("s2_pkt",     64'(STS_PKT_CNT), 64'd1);

    // Non-monotonic timestamp clamps target to zero
    do_reset();
    start();
    IN_VLD = 1'b1; IN_TS = 64'd1000; IN_LEN = 16'd10; IN_LAST = 1'b0;
    step();
    IN_TS = 64'd900; IN_LEN = 16'd20;
    step();
    step();
    IN_VLD = 1'b0;
    check_eq("s3_clamp_vld",  64'(OUT_VLD), 64'd1);
    check_eq("s3_clamp_len",  64'(OUT_LEN), 64'd20);
    check_eq("s3_clamp_late", 64'(STS_LATE_CNT), 64'd1);

    // Stop while waiting for pkt2, then restart with a fresh base timestamp
    do_reset();
    two_pkt_prologue();
    repeat (5) step();
    CTRL_STOP = 1'b1;
    step();
    CTRL_STOP = 1'b0;
    check_eq("s4_stop_busy", 64'(STS_BUSY), 64'd0);
    check_eq("s4_stop_vld",  64'(OUT_VLD), 64'd0);
    check_eq("s4_stop_pkt",  64'(STS_PKT_CNT), 64'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (OUT_VLD) seen++;
      step();
    end
    check_eq("s4_no_release", 64'(seen), 64'd0);
    start();
    IN_VLD = 1'b1; IN_TS = 64'd5000; IN_LEN = 16'd77; IN_LAST = 1'b0;
    step();
    base = cyc;
    check_eq("s4_restart_len", 64'(OUT_LEN), 64'd77);
    IN_TS = 64'd5050; IN_LEN = 16'd88;
    step();
    step();
    IN_VLD = 1'b0;
    wait_out(40);
    check_eq("s4_restart_cycle", 64'(cyc - base), 64'd11);
    check_eq("s4_restart_len2",  64'(OUT_LEN), 64'd88);
    check_eq("s4_restart_late",  64'(STS_LATE_CNT), 64'd0);

    // Stop during a back-pressured SEND: release completes, then idle
    do_reset();
    start();
    OUT_DST_RDY = 1'b0;
    IN_VLD = 1'b1; IN_TS = 64'd0; IN_LEN = 16'd300; IN_LAST = 1'b0;
    step();
    IN_TS = 64'd10; IN_LEN = 16'd5;
    CTRL_STOP = 1'b1;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (OUT_VLD && OUT_LEN == 16'd300) held++;
      step();
      CTRL_STOP = 1'b0;
    end
    check_eq("s5_held_cycles", 64'(held), 64'd10);
    check_eq("s5_pkt_before",  64'(STS_PKT_CNT), 64'd0);
    OUT_DST_RDY = 1'b1;
    step();
    check_eq("s5_busy", 64'(STS_BUSY), 64'd0);
    check_eq("s5_vld",  64'(OUT_VLD), 64'd0);
    check_eq("s5_pkt",  64'(STS_PKT_CNT), 64'd1);
    step();
    IN_VLD = 1'b0;
    check_eq("s5_rdy_idle", 64'(IN_DST_RDY), 64'd0);
    check_eq("s5_pkt_once", 64'(STS_PKT_CNT), 64'd1);

    // Reset in WAIT, then simultaneous start+stop in IDLE
    do_reset();
    two_pkt_prologue();
    repeat (3) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_eq("s6_rst_vld",  64'(OUT_VLD), 64'd0);
    check_eq("s6_rst_len",  64'(OUT_LEN), 64'd0);
    check_eq("s6_rst_busy", 64'(STS_BUSY), 64'd0);
    check_eq("s6_rst_rdy",  64'(IN_DST_RDY), 64'd0);
    check_eq("s6_rst_pkt",  64'(STS_PKT_CNT), 64'd0);
    CTRL_START = 1'b1; CTRL_STOP = 1'b1;
    step();
    CTRL_START = 1'b0; CTRL_STOP = 1'b0;
    check_eq("s6_startstop_busy", 64'(STS_BUSY), 64'd0);
    check_eq("s6_startstop_rdy",  64'(IN_DST_RDY), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
